pupil_centroid_calc: RTL and testbench
======================================

// Module: pupil_centroid_calc
// PURPOSE
//  Computes the centroid (X,Y) of dark pixels over a full frame of the multi-lane Camera Link stream.
//  Dark means pixel < iTHRESHOLD and the pixel is inside a programmable ROI.
//  Runs in the CCLK domain after camera input registering and replaces the single-axis row search.
//  Accumulation is double-buffered against a serial divider, so one result is produced per frame.
// PARAMETERS
//  PIXEL_WIDTH  8    bits per pixel
//  LANES        2    pixels per CCLK (lane 0 = left/even X, lane k = X offset k)
//  HACT         640  active pixels per line; X >= HACT ignored
//  VACT         480  active lines per frame; Y >= VACT ignored
//  COORD_WIDTH  10   width of X/Y coordinates and ROI bounds
//  ACC_WIDTH    32   width of sum_x, sum_y and count; must hold HACT*VACT*HACT
//  MIN_COUNT    16   minimum dark-pixel count for a valid target
// PORTS
//  CCLK         in   1                    camera clock
//  RST_N        in   1                    async active-low reset
//  iFVAL        in   1                    frame valid
//  iLVAL        in   1                    line valid
//  iDVAL        in   1                    data valid; pixel beat only if iFVAL&iLVAL&iDVAL
//  iDATA        in   LANES*PIXEL_WIDTH    lane k = iDATA[k*PIXEL_WIDTH +: PIXEL_WIDTH]
//  iTHRESHOLD   in   PIXEL_WIDTH          dark threshold (strict <)
//  iROI_X0/X1   in   COORD_WIDTH each     inclusive ROI X bounds
//  iROI_Y0/Y1   in   COORD_WIDTH each     inclusive ROI Y bounds
//  oBUSY        out  1                    divider running
//  oVALID       out  1                    1-cycle pulse: new result on outputs
//  oPOINT_X     out  COORD_WIDTH          floor(sum_x/count)
//  oPOINT_Y     out  COORD_WIDTH          floor(sum_y/count)
//  oCOUNT       out  ACC_WIDTH            dark-pixel count of the last frame
//  oNO_TARGET   out  1                    last frame had count < MIN_COUNT
//  oOVERRUN     out  1                    1-cycle pulse: frame end while divider busy; that frame is dropped
// BEHAVIOUR
//  - Reset: every output and internal register is 0; FSM = IDLE. Reset mid-divide aborts the divide with no oVALID.
//  - Edges use iFVAL/iLVAL registered once internally. FVAL rise clears hcount, vcount, sums and count, and latches ROI and threshold.
//    ROI and threshold changes mid-frame have no effect until the next FVAL rise.
//  - hcount counts beats within a line and clears on LVAL rise. vcount increments on LVAL fall.
//  - Pixel X = hcount*LANES + k; Y = vcount.
//  - Per beat, every lane satisfying dark & ROI & X<HACT & Y<VACT is added in the same cycle:
//    count += n_dark; sum_x += sum of X; sum_y += n_dark*Y.
//  - FSM IDLE -> DIV_X -> DIV_Y -> DONE -> IDLE. Leaving IDLE happens on an FVAL fall with count >= MIN_COUNT.
//    On that edge sums and count are snapshotted into divider registers and the accumulators are free for the next frame.
//  - DIV_X and DIV_Y are restoring dividers, ACC_WIDTH cycles each, 1 quotient bit per cycle; truncating; low COORD_WIDTH bits kept.
//  - DONE updates oPOINT_X/Y, oCOUNT, oNO_TARGET=0 and pulses oVALID.
//    oVALID is high exactly 2*ACC_WIDTH+2 cycles after the first cycle with iFVAL=0 (66 cycles at default).
//  - count < MIN_COUNT at FVAL fall (including 0): no divide. oPOINT_X/Y hold their previous values;
//    oCOUNT updates, oNO_TARGET=1, oVALID pulses 2 cycles after the first cycle with iFVAL=0.
//  - FVAL fall while FSM != IDLE: that frame's result is discarded, oOVERRUN pulses, and the current divide completes untouched.
//  - oBUSY = (FSM in DIV_X or DIV_Y or DONE).
//  - A beat with iDVAL=0 neither advances hcount nor accumulates. Lines/beats outside iFVAL are ignored.
// TESTING
//  1 4x4 block of 0x10 at X100..103, Y50..53; rest 0xFF; threshold 0x20; full ROI
//    -> oCOUNT=16, X=101, Y=51, oVALID 66 cycles after FVAL fall.
//  2 only 3 dark pixels -> oNO_TARGET=1, oCOUNT=3, oPOINT_X/Y unchanged from test 1, oVALID 2 cycles after FVAL fall.
//  3 test-1 image with ROI X200..300 -> oCOUNT=0, oNO_TARGET=1; ROI changed to full mid-frame -> still 0.
//  4 MIN_COUNT=1; single dark pixel on lane 1 at hcount 10, line 7 -> X=21, Y=7.
//  5 RST_N low during DIV_X -> all outputs 0, no oVALID; next frame (test 1) gives X=101, Y=51.
//  6 back-to-back frames, vblank 70 cycles, blocks at (101,51) then (301,201) -> two correct pulses, no oOVERRUN;
//    vblank 20 cycles -> oOVERRUN pulses, second frame dropped.

Source files
------------

// File: rtl/pupil_centroid_calc_if.sv
// Pixel stream, configuration and centroid result bundle for pupil_centroid_calc.
// The camera side drives through master; the centroid block attaches as slave.
interface pupil_centroid_calc_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 2,
  parameter int COORD_WIDTH = 10,
  parameter int ACC_WIDTH   = 32
);
  logic                         iFVAL;
  logic                         iLVAL;
  logic                         iDVAL;
  logic [LANES*PIXEL_WIDTH-1:0] iDATA;
  logic [PIXEL_WIDTH-1:0]       iTHRESHOLD;
  logic [COORD_WIDTH-1:0]       iROI_X0;
  logic [COORD_WIDTH-1:0]       iROI_X1;
  logic [COORD_WIDTH-1:0]       iROI_Y0;
  logic [COORD_WIDTH-1:0]       iROI_Y1;
  logic                         oBUSY;
  logic                         oVALID;
  logic [COORD_WIDTH-1:0]       oPOINT_X;
  logic [COORD_WIDTH-1:0]       oPOINT_Y;
  logic [ACC_WIDTH-1:0]         oCOUNT;
  logic                         oNO_TARGET;
  logic                         oOVERRUN;

  modport master (
    output iFVAL, iLVAL, iDVAL, iDATA, iTHRESHOLD,
           iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
    input  oBUSY, oVALID, oPOINT_X, oPOINT_Y, oCOUNT, oNO_TARGET, oOVERRUN
  );

  modport slave (
    input  iFVAL, iLVAL, iDVAL, iDATA, iTHRESHOLD,
           iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
    output oBUSY, oVALID, oPOINT_X, oPOINT_Y, oCOUNT, oNO_TARGET, oOVERRUN
  );
endinterface

// File: rtl/pupil_centroid_calc.sv
// Per-frame centroid of dark pixels inside an ROI; accumulators feed a serial
// restoring divider so the next frame can accumulate while the result is computed.
//
// state   | meaning
// IDLE    | accumulating; waits for frame end with enough dark pixels
// DIV_X   | sum_x / count, one quotient bit per cycle
// DIV_Y   | sum_y / count, one quotient bit per cycle; last bit publishes the result
// DONE    | result pulse visible; returns to IDLE
module pupil_centroid_calc #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 2,
  parameter int HACT        = 640,
  parameter int VACT        = 480,
  parameter int COORD_WIDTH = 10,
  parameter int ACC_WIDTH   = 32,
  parameter int MIN_COUNT   = 16
) (
  input logic                  CCLK,
  input logic                  RST_N,
  pupil_centroid_calc_if.slave bus
);

  localparam int XW = COORD_WIDTH + $clog2(LANES) + 1;
  localparam int BW = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_DONE} state_t;

  logic                         r_fval, r_fval_q, r_lval, r_lval_q, r_dval;
  logic [LANES*PIXEL_WIDTH-1:0] r_data;
  logic [PIXEL_WIDTH-1:0]       r_thr;
  logic [COORD_WIDTH-1:0]       r_roi_x0, r_roi_x1, r_roi_y0, r_roi_y1;
  logic [COORD_WIDTH-1:0]       r_hcount, r_vcount;
  logic [ACC_WIDTH-1:0]         r_sum_x, r_sum_y, r_count;

  state_t                       r_state;
  logic [BW-1:0]                r_bit;
  logic [ACC_WIDTH-1:0]         r_rem, r_quo, r_den, r_sy;
  logic [COORD_WIDTH-1:0]       r_qx;
  logic                         r_busy, r_valid, r_no_tgt, r_ovr;
  logic [COORD_WIDTH-1:0]       r_px, r_py;
  logic [ACC_WIDTH-1:0]         r_cnt_o;

  logic                         w_fval_rise, w_fval_fall, w_lval_rise, w_lval_fall, w_beat;
  logic [PIXEL_WIDTH-1:0]       w_thr;
  logic [COORD_WIDTH-1:0]       w_x0, w_x1, w_y0, w_y1;
  logic [COORD_WIDTH-1:0]       w_hbase, w_vbase;
  logic                         w_y_ok;
  logic [LANES-1:0]             w_hit;
  logic [ACC_WIDTH-1:0]         w_xterm [LANES];
  logic [ACC_WIDTH-1:0]         w_add_x, w_add_y, w_n_dark;
  logic [ACC_WIDTH-1:0]         w_cnt_base, w_sx_base, w_sy_base;

  logic [ACC_WIDTH:0]           w_step_tmp, w_step_sub;
  logic                         w_step_ge;
  logic [ACC_WIDTH-1:0]         w_step_rem, w_step_quo;

  assign w_fval_rise = r_fval & ~r_fval_q;
  assign w_fval_fall = ~r_fval & r_fval_q;
  assign w_lval_rise = r_fval & r_lval & ~r_lval_q;
  assign w_lval_fall = r_fval & ~r_lval & r_lval_q;
  assign w_beat      = r_fval & r_lval & r_dval;

  // The frame-start cycle uses the live configuration it is about to latch.
  assign w_thr = w_fval_rise ? bus.iTHRESHOLD : r_thr;
  assign w_x0  = w_fval_rise ? bus.iROI_X0    : r_roi_x0;
  assign w_x1  = w_fval_rise ? bus.iROI_X1    : r_roi_x1;
  assign w_y0  = w_fval_rise ? bus.iROI_Y0    : r_roi_y0;
  assign w_y1  = w_fval_rise ? bus.iROI_Y1    : r_roi_y1;

  assign w_hbase = (w_fval_rise || w_lval_rise) ? '0 : r_hcount;
  assign w_vbase = w_fval_rise ? '0 : r_vcount;
  assign w_y_ok  = (w_vbase >= w_y0) && (w_vbase <= w_y1) && (32'(w_vbase) < VACT);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [XW-1:0]          w_x;
    logic [PIXEL_WIDTH-1:0] w_pix;
    assign w_x        = XW'(w_hbase) * XW'(LANES) + XW'(k);
    assign w_pix      = r_data[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_hit[k]   = w_beat && (w_pix < w_thr) && w_y_ok &&
                        (w_x >= XW'(w_x0)) && (w_x <= XW'(w_x1)) && (32'(w_x) < HACT);
    assign w_xterm[k] = w_hit[k] ? ACC_WIDTH'(w_x) : '0;
  end

  always_comb begin
    w_add_x  = '0;
    w_n_dark = '0;
    for (int k = 0; k < LANES; k++) begin
      w_add_x  = w_add_x + w_xterm[k];
      w_n_dark = w_n_dark + ACC_WIDTH'(w_hit[k]);
    end
  end

  assign w_add_y    = w_n_dark * ACC_WIDTH'(w_vbase);
  assign w_cnt_base = w_fval_rise ? '0 : r_count;
  assign w_sx_base  = w_fval_rise ? '0 : r_sum_x;
  assign w_sy_base  = w_fval_rise ? '0 : r_sum_y;

  // Partial remainder stays below the divisor, so bit ACC_WIDTH of the
  // difference is exactly the borrow.
  assign w_step_tmp = {r_rem, r_quo[ACC_WIDTH-1]};
  assign w_step_sub = w_step_tmp - {1'b0, r_den};
  assign w_step_ge  = ~w_step_sub[ACC_WIDTH];
  assign w_step_rem = w_step_ge ? w_step_sub[ACC_WIDTH-1:0] : w_step_tmp[ACC_WIDTH-1:0];
  assign w_step_quo = {r_quo[ACC_WIDTH-2:0], w_step_ge};

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fval   <= 1'b0;
      r_fval_q <= 1'b0;
      r_lval   <= 1'b0;
      r_lval_q <= 1'b0;
      r_dval   <= 1'b0;
      r_data   <= '0;
      r_thr    <= '0;
      r_roi_x0 <= '0;
      r_roi_x1 <= '0;
      r_roi_y0 <= '0;
      r_roi_y1 <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_sum_x  <= '0;
      r_sum_y  <= '0;
      r_count  <= '0;
    end else begin
      r_fval   <= bus.iFVAL;
      r_fval_q <= r_fval;
      r_lval   <= bus.iLVAL;
      r_lval_q <= r_lval;
      r_dval   <= bus.iDVAL;
      r_data   <= bus.iDATA;
      if (w_fval_rise) begin
        r_thr    <= bus.iTHRESHOLD;
        r_roi_x0 <= bus.iROI_X0;
        r_roi_x1 <= bus.iROI_X1;
        r_roi_y0 <= bus.iROI_Y0;
        r_roi_y1 <= bus.iROI_Y1;
      end
      if (w_fval_rise)
        r_vcount <= '0;
      else if (w_lval_fall && (r_vcount != '1))
        r_vcount <= r_vcount + 1'b1;
      // hcount saturates so runaway lines land beyond HACT instead of wrapping.
      if (w_beat)
        r_hcount <= (w_hbase == '1) ? w_hbase : w_hbase + 1'b1;
      else if (w_fval_rise || w_lval_rise)
        r_hcount <= '0;
      r_count <= w_cnt_base + w_n_dark;
      r_sum_x <= w_sx_base + w_add_x;
      r_sum_y <= w_sy_base + w_add_y;
    end
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_bit    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_den    <= '0;
      r_sy     <= '0;
      r_qx     <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_no_tgt <= 1'b0;
      r_ovr    <= 1'b0;
      r_px     <= '0;
      r_py     <= '0;
      r_cnt_o  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ovr   <= w_fval_fall && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_fval_fall) begin
            if (r_count >= ACC_WIDTH'(MIN_COUNT)) begin
              r_state <= S_DIV_X;
              r_busy  <= 1'b1;
              r_quo   <= r_sum_x;
              r_rem   <= '0;
              r_den   <= r_count;
              r_sy    <= r_sum_y;
              r_bit   <= BW'(ACC_WIDTH - 1);
            end else begin
              r_cnt_o  <= r_count;
              r_no_tgt <= 1'b1;
              r_valid  <= 1'b1;
            end
          end
        end
        S_DIV_X: begin
          if (r_bit == '0) begin
            r_qx    <= w_step_quo[COORD_WIDTH-1:0];
            r_quo   <= r_sy;
            r_rem   <= '0;
            r_bit   <= BW'(ACC_WIDTH - 1);
            r_state <= S_DIV_Y;
          end else begin
            r_quo <= w_step_quo;
            r_rem <= w_step_rem;
            r_bit <= r_bit - 1'b1;
          end
        end
        S_DIV_Y: begin
          if (r_bit == '0) begin
            r_px     <= r_qx;
            r_py     <= w_step_quo[COORD_WIDTH-1:0];
            r_cnt_o  <= r_den;
            r_no_tgt <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_quo <= w_step_quo;
            r_rem <= w_step_rem;
            r_bit <= r_bit - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBUSY      = r_busy;
  assign bus.oVALID     = r_valid;
  assign bus.oPOINT_X   = r_px;
  assign bus.oPOINT_Y   = r_py;
  assign bus.oCOUNT     = r_cnt_o;
  assign bus.oNO_TARGET = r_no_tgt;
  assign bus.oOVERRUN   = r_ovr;

endmodule

// File: tb/tb_pupil_centroid_calc.sv
// Directed bench for pupil_centroid_calc: small synthetic frames with dark blocks,
// checking centroid, count, result timing, ROI/threshold latching, reset abort and overrun.
module tb_pupil_centroid_calc;
  localparam int PW = 8;
  localparam int LN = 2;
  localparam int CW = 10;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pupil_centroid_calc_if #(.PIXEL_WIDTH(PW), .LANES(LN), .COORD_WIDTH(CW), .ACC_WIDTH(AW)) bus0 ();
  pupil_centroid_calc_if #(.PIXEL_WIDTH(PW), .LANES(LN), .COORD_WIDTH(CW), .ACC_WIDTH(AW)) bus1 ();

  pupil_centroid_calc u_dut (.CCLK(clk), .RST_N(rst_n), .bus(bus0));
  pupil_centroid_calc #(.MIN_COUNT(1)) u_dut1 (.CCLK(clk), .RST_N(rst_n), .bus(bus1));

  int n_chk = 0;
  int n_err = 0;
  int n_val0 = 0;
  int n_ovr0 = 0;
  int bx, by, bw, bh;
  logic [7:0] dark_val = 8'h10;
  logic [7:0] thr = 8'h20;

  always @(negedge clk) begin
    if (bus0.oVALID)   n_val0++;
    if (bus0.oOVERRUN) n_ovr0++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic d, input logic [15:0] data);
    bus0.iFVAL = f; bus0.iLVAL = l; bus0.iDVAL = d; bus0.iDATA = data;
    bus1.iFVAL = f; bus1.iLVAL = l; bus1.iDVAL = d; bus1.iDATA = data;
  endtask

  task automatic set_cfg(input logic [7:0] t, input int x0, input int x1, input int y0, input int y1);
    bus0.iTHRESHOLD = t; bus0.iROI_X0 = CW'(x0); bus0.iROI_X1 = CW'(x1);
    bus0.iROI_Y0 = CW'(y0); bus0.iROI_Y1 = CW'(y1);
    bus1.iTHRESHOLD = t; bus1.iROI_X0 = CW'(x0); bus1.iROI_X1 = CW'(x1);
    bus1.iROI_Y0 = CW'(y0); bus1.iROI_Y1 = CW'(y1);
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    return (x >= bx && x < bx + bw && y >= by && y < by + bh) ? dark_val : 8'hFF;
  endfunction

  // Rows outside the block are one beat long; block rows run just past the block.
  task automatic send_frame(input int x, input int y, input int w, input int h,
                            input bit stall, input bit roi_full_mid);
    bx = x; by = y; bw = w; bh = h;
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) tick();
    if (roi_full_mid) set_cfg(thr, 0, 1023, 0, 1023);
    for (int row = 0; row < y + h; row++) begin
      int nb;
      nb = (row >= y && row < y + h) ? (x + w - 1) / 2 + 1 : 1;
      for (int b = 0; b < nb; b++) begin
        if (stall) begin
          drive(1'b1, 1'b1, 1'b0, 16'h0000);
          tick();
        end
        drive(1'b1, 1'b1, 1'b1, {pix(2 * b + 1, row), pix(2 * b, row)});
        tick();
      end
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
    end
  endtask

  task automatic end_frame(input bit do_wait, output int k0, output int k1,
                           output int pulses, output int busy10);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    k0 = 0; k1 = 0; pulses = 0; busy10 = 0;
    if (do_wait) begin
      for (int k = 1; k <= 70; k++) begin
        tick();
        if (bus0.oVALID) begin
          pulses++;
          if (k0 == 0) k0 = k;
        end
        if (bus1.oVALID && k1 == 0) k1 = k;
        if (k == 10) busy10 = int'(bus0.oBUSY);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1, pl, b10, v, o;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    set_cfg(thr, 0, 1023, 0, 1023);
    repeat (3) tick();
    check("rst_valid", bus0.oVALID, 0);
    check("rst_busy", bus0.oBUSY, 0);
    check("rst_x", bus0.oPOINT_X, 0);
    check("rst_y", bus0.oPOINT_Y, 0);
    check("rst_count", bus0.oCOUNT, 0);
    check("rst_notgt", bus0.oNO_TARGET, 0);
    check("rst_ovr", bus0.oOVERRUN, 0);
    rst_n = 1'b1;
    tick();

    // 4x4 block at X100..103, Y50..53
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t1_latency", k0, 66);
    check("t1_pulses", pl, 1);
    check("t1_busy", b10, 1);
    check("t1_x", bus0.oPOINT_X, 101);
    check("t1_y", bus0.oPOINT_Y, 51);
    check("t1_count", bus0.oCOUNT, 16);
    check("t1_notgt", bus0.oNO_TARGET, 0);

    // three dark pixels: below MIN_COUNT, point holds
    send_frame(100, 50, 3, 1, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t2_latency", k0, 2);
    check("t2_busy", b10, 0);
    check("t2_count", bus0.oCOUNT, 3);
    check("t2_notgt", bus0.oNO_TARGET, 1);
    check("t2_x_hold", bus0.oPOINT_X, 101);
    check("t2_y_hold", bus0.oPOINT_Y, 51);

    // ROI excludes the block
    set_cfg(thr, 200, 300, 0, 1023);
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t3_latency", k0, 2);
    check("t3_count", bus0.oCOUNT, 0);
    check("t3_notgt", bus0.oNO_TARGET, 1);

    // ROI widened mid-frame must not apply until next frame
    send_frame(100, 50, 4, 4, 1'b0, 1'b1);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t3_mid_count", bus0.oCOUNT, 0);

    // pixel equal to threshold is not dark; one below is
    dark_val = 8'h20;
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("thr_eq_count", bus0.oCOUNT, 0);
    dark_val = 8'h1F;
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("thr_lt_count", bus0.oCOUNT, 16);
    check("thr_lt_latency", k0, 66);
    dark_val = 8'h10;

    // DVAL=0 stall beats carry dark data and must be ignored
    send_frame(200, 100, 4, 4, 1'b1, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("stall_count", bus0.oCOUNT, 16);
    check("stall_x", bus0.oPOINT_X, 201);
    check("stall_y", bus0.oPOINT_Y, 101);

    // single dark pixel on lane 1 at hcount 10, line 7
    send_frame(21, 7, 1, 1, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t4_min1_latency", k1, 66);
    check("t4_min1_x", bus1.oPOINT_X, 21);
    check("t4_min1_y", bus1.oPOINT_Y, 7);
    check("t4_min1_count", bus1.oCOUNT, 1);
    check("t4_dflt_count", bus0.oCOUNT, 1);
    check("t4_dflt_notgt", bus0.oNO_TARGET, 1);
    check("t4_dflt_latency", k0, 2);

    // reset during DIV_X aborts the divide
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b0, k0, k1, pl, b10);
    repeat (10) tick();
    check("t5_busy_pre", bus0.oBUSY, 1);
    rst_n = 1'b0;
    tick();
    v = n_val0;
    check("t5_rst_busy", bus0.oBUSY, 0);
    check("t5_rst_x", bus0.oPOINT_X, 0);
    check("t5_rst_y", bus0.oPOINT_Y, 0);
    check("t5_rst_count", bus0.oCOUNT, 0);
    check("t5_rst_notgt", bus0.oNO_TARGET, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    check("t5_no_valid", n_val0, v);
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t5_after_x", bus0.oPOINT_X, 101);
    check("t5_after_y", bus0.oPOINT_Y, 51);
    check("t5_after_latency", k0, 66);

    // back-to-back frames with a long vblank
    o = n_ovr0;
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t6a_first_latency", k0, 66);
    check("t6a_first_x", bus0.oPOINT_X, 101);
    check("t6a_first_y", bus0.oPOINT_Y, 51);
    send_frame(300, 200, 4, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t6a_second_latency", k0, 66);
    check("t6a_second_x", bus0.oPOINT_X, 301);
    check("t6a_second_y", bus0.oPOINT_Y, 201);
    check("t6a_no_overrun", n_ovr0, o);

    // short vblank: second frame ends while dividing and is dropped
    v = n_val0;
    o = n_ovr0;
    send_frame(100, 50, 4, 4, 1'b0, 1'b0);
    end_frame(1'b0, k0, k1, pl, b10);
    repeat (19) tick();
    send_frame(2, 0, 5, 4, 1'b0, 1'b0);
    end_frame(1'b1, k0, k1, pl, b10);
    check("t6b_overrun", n_ovr0, o + 1);
    check("t6b_valids", n_val0, v + 1);
    check("t6b_count", bus0.oCOUNT, 16);
    check("t6b_x", bus0.oPOINT_X, 101);
    check("t6b_y", bus0.oPOINT_Y, 51);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
